// File: rtl/dot_product_pkg.sv
// Shared types and width helpers for the dot-product engine.
package dot_product_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRdA,
    StRdB,
    StMac,
    StWr
  } state_e;

  localparam int unsigned StatBusy  = 0;
  localparam int unsigned StatDone  = 1;
  localparam int unsigned StatOvf   = 2;
  localparam int unsigned StatAbort = 3;

  function automatic int unsigned calc_lanes(input int unsigned data_w,
                                             input int unsigned elem_w);
    return data_w / elem_w;
  endfunction

  // Lane-sum width: ACC_W+1 for legal parameters, widened if ACC_W is too narrow to hold a word.
  function automatic int unsigned lane_sum_width(input int unsigned acc_w,
                                                 input int unsigned elem_w,
                                                 input int unsigned lanes);
    int unsigned need;
    need = 2 * elem_w + $clog2(lanes) + 1;
    return (need > acc_w + 1) ? need : acc_w + 1;
  endfunction

endpackage

// File: rtl/dot_product_mac_lanes.sv
// Combinational LANES-wide multiply with per-lane masking and a summing tree.
module dot_product_mac_lanes
  import dot_product_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ELEM_W = 8,
  parameter int unsigned LANES  = calc_lanes(DATA_W, ELEM_W),
  parameter int unsigned SUM_W  = 33
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [LANES-1:0]  lane_mask_i,
  input  logic              signed_i,
  output logic [SUM_W-1:0]  sum_o
);

  localparam int unsigned ProdW = 2 * ELEM_W;

  logic [ELEM_W-1:0] a_e, b_e;
  logic [ProdW-1:0]  a_x, b_x, prod;

  always_comb begin
    sum_o = '0;
    a_e   = '0;
    b_e   = '0;
    a_x   = '0;
    b_x   = '0;
    prod  = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      a_e  = lane_mask_i[i] ? a_i[i*ELEM_W +: ELEM_W] : '0;
      b_e  = lane_mask_i[i] ? b_i[i*ELEM_W +: ELEM_W] : '0;
      a_x  = signed_i ? ProdW'($signed(a_e)) : ProdW'(a_e);
      b_x  = signed_i ? ProdW'($signed(b_e)) : ProdW'(b_e);
      // Low 2*ELEM_W bits of the extended product are exact in either mode.
      prod = a_x * b_x;
      sum_o = sum_o + (signed_i ? SUM_W'($signed(prod)) : SUM_W'(prod));
    end
  end

endmodule

// File: rtl/dot_product_engine.sv
// Dot-product control core: fetches packed A/B words, accumulates, writes the result.
module dot_product_engine
  import dot_product_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ELEM_W = 8,
  parameter int unsigned ACC_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_in,
  input  logic              abort_in,
  input  logic              signed_in,
  input  logic              sat_in,
  input  logic [ADDR_W-1:0] addr_a_in,
  input  logic [ADDR_W-1:0] addr_b_in,
  input  logic [31:0]       length_in,
  input  logic [ADDR_W-1:0] addr_out_in,
  output logic [31:0]       status_out,
  output logic              read_req,
  output logic [ADDR_W-1:0] read_addr,
  input  logic [DATA_W-1:0] read_data,
  input  logic              read_data_valid,
  output logic              write_req,
  output logic [ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0] write_data,
  input  logic              write_done
);

  localparam int unsigned LANES = calc_lanes(DATA_W, ELEM_W);
  localparam int unsigned SUM_W = lane_sum_width(ACC_W, ELEM_W, LANES);
  localparam int unsigned TOT_W = SUM_W + 1;
  localparam int unsigned REM_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [ADDR_W-1:0] WordBytes = ADDR_W'(DATA_W / 8);

  state_e            state_q, state_d;
  logic              start_q, start_d;
  logic              busy_q, busy_d, done_q, done_d, ovf_q, ovf_d, aborted_q, aborted_d;
  logic              abort_pend_q, abort_pend_d;
  logic              signed_q, signed_d, sat_q, sat_d;
  logic [ADDR_W-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d, addr_out_q, addr_out_d;
  logic [31:0]       words_q, words_d;
  logic [REM_W-1:0]  rem_q, rem_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic              read_req_q, read_req_d, write_req_q, write_req_d;
  logic [ADDR_W-1:0] read_addr_q, read_addr_d, write_addr_q, write_addr_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;

  logic [LANES-1:0]     lane_mask;
  logic [SUM_W-1:0]     lane_sum;
  logic [TOT_W-1:0]     acc_ext, sum_ext, total;
  logic [TOT_W-ACC_W:0] upper;
  logic [ACC_W-1:0]     sat_val, acc_mac;
  logic                 mac_ovf;
  logic [31:0]          rem_full;
  logic                 start_edge, req_out, strobe;

  dot_product_mac_lanes #(
    .DATA_W (DATA_W),
    .ELEM_W (ELEM_W),
    .LANES  (LANES),
    .SUM_W  (SUM_W)
  ) u_mac_lanes (
    .a_i         (a_q),
    .b_i         (b_q),
    .lane_mask_i (lane_mask),
    .signed_i    (signed_q),
    .sum_o       (lane_sum)
  );

  // Only the final word of a ragged vector has its upper lanes masked.
  always_comb begin
    lane_mask = '1;
    if (words_q == 32'd1 && rem_q != '0) begin
      for (int i = 0; i < int'(LANES); i++) begin
        lane_mask[i] = (i < int'(rem_q));
      end
    end
  end

  always_comb begin
    acc_ext = signed_q ? TOT_W'($signed(acc_q)) : TOT_W'(acc_q);
    sum_ext = signed_q ? TOT_W'($signed(lane_sum)) : TOT_W'(lane_sum);
    total   = acc_ext + sum_ext;
    upper   = total[TOT_W-1:ACC_W-1];
    if (signed_q) begin
      mac_ovf = !((&upper) || !(|upper));
      sat_val = total[TOT_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      mac_ovf = |upper[TOT_W-ACC_W:1];
      sat_val = '1;
    end
    acc_mac = (mac_ovf && sat_q) ? sat_val : total[ACC_W-1:0];
  end

  always_comb begin
    state_d      = state_q;
    start_d      = start_in;
    busy_d       = busy_q;
    done_d       = done_q;
    ovf_d        = ovf_q;
    aborted_d    = aborted_q;
    abort_pend_d = abort_pend_q;
    signed_d     = signed_q;
    sat_d        = sat_q;
    addr_a_d     = addr_a_q;
    addr_b_d     = addr_b_q;
    addr_out_d   = addr_out_q;
    words_d      = words_q;
    rem_d        = rem_q;
    acc_d        = acc_q;
    a_d          = a_q;
    b_d          = b_q;
    read_req_d   = read_req_q;
    read_addr_d  = read_addr_q;
    write_req_d  = write_req_q;
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;

    start_edge = start_in & ~start_q;
    req_out    = read_req_q | write_req_q;
    strobe     = (read_req_q & read_data_valid) | (write_req_q & write_done);
    rem_full   = length_in % LANES;

    if (state_q != StIdle && (abort_in || abort_pend_q)) begin
      // An in-flight request is allowed to complete; its response is dropped.
      if (req_out && !strobe) begin
        abort_pend_d = 1'b1;
      end else begin
        state_d      = StIdle;
        read_req_d   = 1'b0;
        write_req_d  = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        aborted_d    = 1'b1;
        abort_pend_d = 1'b0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_edge) begin
            addr_a_d     = addr_a_in;
            addr_b_d     = addr_b_in;
            addr_out_d   = addr_out_in;
            words_d      = length_in / LANES + 32'(rem_full != 32'd0);
            rem_d        = REM_W'(rem_full);
            signed_d     = signed_in;
            sat_d        = sat_in;
            acc_d        = '0;
            busy_d       = 1'b1;
            done_d       = 1'b0;
            ovf_d        = 1'b0;
            aborted_d    = 1'b0;
            abort_pend_d = 1'b0;
            state_d      = (length_in == 32'd0) ? StWr : StRdA;
          end
        end
        StRdA: begin
          if (!read_req_q) begin
            read_req_d  = 1'b1;
            read_addr_d = addr_a_q;
          end else if (read_data_valid) begin
            read_req_d = 1'b0;
            a_d        = read_data;
            state_d    = StRdB;
          end
        end
        StRdB: begin
          if (!read_req_q) begin
            read_req_d  = 1'b1;
            read_addr_d = addr_b_q;
          end else if (read_data_valid) begin
            read_req_d = 1'b0;
            b_d        = read_data;
            addr_a_d   = addr_a_q + WordBytes;
            addr_b_d   = addr_b_q + WordBytes;
            state_d    = StMac;
          end
        end
        StMac: begin
          acc_d   = acc_mac;
          ovf_d   = ovf_q | mac_ovf;
          words_d = words_q - 32'd1;
          state_d = (words_q == 32'd1) ? StWr : StRdA;
        end
        StWr: begin
          if (!write_req_q) begin
            write_req_d  = 1'b1;
            write_addr_d = addr_out_q;
            write_data_d = signed_q ? DATA_W'($signed(acc_q)) : DATA_W'(acc_q);
          end else if (write_done) begin
            write_req_d = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            state_d     = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ovf_q        <= 1'b0;
      aborted_q    <= 1'b0;
      abort_pend_q <= 1'b0;
      signed_q     <= 1'b0;
      sat_q        <= 1'b0;
      addr_a_q     <= '0;
      addr_b_q     <= '0;
      addr_out_q   <= '0;
      words_q      <= '0;
      rem_q        <= '0;
      acc_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      read_req_q   <= 1'b0;
      read_addr_q  <= '0;
      write_req_q  <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
    end else begin
      state_q      <= state_d;
      start_q      <= start_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      ovf_q        <= ovf_d;
      aborted_q    <= aborted_d;
      abort_pend_q <= abort_pend_d;
      signed_q     <= signed_d;
      sat_q        <= sat_d;
      addr_a_q     <= addr_a_d;
      addr_b_q     <= addr_b_d;
      addr_out_q   <= addr_out_d;
      words_q      <= words_d;
      rem_q        <= rem_d;
      acc_q        <= acc_d;
      a_q          <= a_d;
      b_q          <= b_d;
      read_req_q   <= read_req_d;
      read_addr_q  <= read_addr_d;
      write_req_q  <= write_req_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
    end
  end

  always_comb begin
    status_out            = '0;
    status_out[StatBusy]  = busy_q;
    status_out[StatDone]  = done_q;
    status_out[StatOvf]   = ovf_q;
    status_out[StatAbort] = aborted_q;
  end

  assign read_req   = read_req_q;
  assign read_addr  = read_addr_q;
  assign write_req  = write_req_q;
  assign write_addr = write_addr_q;
  assign write_data = write_data_q;

endmodule

// File: tb/tb_dot_product_engine.sv
// Scoreboard bench: jobs push expected writes, per-DUT monitors pop and compare on write handshakes.
module tb_dot_product_engine;

  localparam logic [31:0] ResAddr   = 32'h0000_0100;
  localparam logic [31:0] Res16Addr = 32'h0000_0200;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start_in, abort_in, signed_in, sat_in;
  logic [31:0] addr_a_in, addr_b_in, length_in, addr_out_in, status_out;
  logic        read_req, read_data_valid, write_req, write_done;
  logic [31:0] read_addr, read_data, write_addr, write_data;

  logic        s_start, s_sat, s_rreq, s_rvalid, s_wreq, s_wdone;
  logic [31:0] s_length, s_status, s_raddr, s_waddr, s_wdata;

  int   checks = 0;
  int   failures = 0;
  int   rd_cnt = 0;
  int   mem_lat = 1;
  logic [31:0] mem [0:63];
  wr_t  exp_q[$];
  wr_t  exp16_q[$];

  dot_product_engine dut (
    .clk             (clk),
    .rst             (rst),
    .start_in        (start_in),
    .abort_in        (abort_in),
    .signed_in       (signed_in),
    .sat_in          (sat_in),
    .addr_a_in       (addr_a_in),
    .addr_b_in       (addr_b_in),
    .length_in       (length_in),
    .addr_out_in     (addr_out_in),
    .status_out      (status_out),
    .read_req        (read_req),
    .read_addr       (read_addr),
    .read_data       (read_data),
    .read_data_valid (read_data_valid),
    .write_req       (write_req),
    .write_addr      (write_addr),
    .write_data      (write_data),
    .write_done      (write_done)
  );

  dot_product_engine #(
    .ACC_W (16)
  ) dut16 (
    .clk             (clk),
    .rst             (rst),
    .start_in        (s_start),
    .abort_in        (1'b0),
    .signed_in       (1'b0),
    .sat_in          (s_sat),
    .addr_a_in       (32'h0000_0000),
    .addr_b_in       (32'h0000_1000),
    .length_in       (s_length),
    .addr_out_in     (Res16Addr),
    .status_out      (s_status),
    .read_req        (s_rreq),
    .read_addr       (s_raddr),
    .read_data       (32'hFFFF_FFFF),
    .read_data_valid (s_rvalid),
    .write_req       (s_wreq),
    .write_addr      (s_waddr),
    .write_data      (s_wdata),
    .write_done      (s_wdone)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // Memory for the main DUT, response after mem_lat cycles of request.
  initial begin
    int rd_wait;
    rd_wait = 0;
    read_data_valid = 1'b0;
    read_data = '0;
    write_done = 1'b0;
    forever begin
      @(negedge clk);
      read_data_valid = 1'b0;
      write_done = 1'b0;
      if (read_req) begin
        rd_wait++;
        if (rd_wait >= mem_lat) begin
          read_data_valid = 1'b1;
          read_data = mem[read_addr[7:2]];
          rd_wait = 0;
          rd_cnt++;
        end
      end else begin
        rd_wait = 0;
      end
      if (write_req) write_done = 1'b1;
    end
  end

  initial begin
    s_rvalid = 1'b0;
    s_wdone = 1'b0;
    forever begin
      @(negedge clk);
      s_rvalid = s_rreq;
      s_wdone = s_wreq;
    end
  end

  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      #1;
      if (write_req && write_done) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write actual=0x%08h@0x%08h required=none", write_data,
                   write_addr);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", write_addr, e.addr);
          check("wr_data", write_data, e.data);
        end
      end
    end
  end

  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      #1;
      if (s_wreq && s_wdone) begin
        if (exp16_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write16 actual=0x%08h required=none", s_wdata);
        end else begin
          e = exp16_q.pop_front();
          check("wr16_addr", s_waddr, e.addr);
          check("wr16_data", s_wdata, e.data);
        end
      end
    end
  end

  task automatic wait_idle(input string name, input int limit);
    bit fin;
    fin = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (!status_out[0]) begin
        fin = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({name, "_finished"}, {31'd0, fin}, 32'd1);
  endtask

  task automatic run_job(input string name, input logic sgn, input logic sat,
                         input logic [31:0] aa, input logic [31:0] ab, input logic [31:0] len,
                         input bit push, input logic [31:0] exp_data,
                         input logic [31:0] exp_status, input int exp_reads);
    int r0;
    @(negedge clk);
    signed_in = sgn;
    sat_in = sat;
    addr_a_in = aa;
    addr_b_in = ab;
    length_in = len;
    addr_out_in = ResAddr;
    if (push) exp_q.push_back('{addr: ResAddr, data: exp_data});
    r0 = rd_cnt;
    start_in = 1'b1;
    @(negedge clk);
    check({name, "_busy"}, status_out & 32'h1, 32'h1);
    wait_idle(name, 200);
    start_in = 1'b0;
    check({name, "_status"}, status_out, exp_status);
    check({name, "_reads"}, 32'(rd_cnt - r0), 32'(exp_reads));
  endtask

  task automatic run16(input string name, input logic sat, input logic [31:0] exp_data);
    bit fin;
    @(negedge clk);
    s_sat = sat;
    s_length = 32'd1200;
    exp16_q.push_back('{addr: Res16Addr, data: exp_data});
    s_start = 1'b1;
    @(negedge clk);
    fin = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (!s_status[0]) begin
        fin = 1'b1;
        break;
      end
      @(negedge clk);
    end
    s_start = 1'b0;
    check({name, "_finished"}, {31'd0, fin}, 32'd1);
    check({name, "_status"}, s_status, 32'h6);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r0;
    bit seen;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[0]  = 32'h0403_0201;  mem[32] = 32'h0101_0101;
    mem[1]  = 32'hFFFF_FFFF;  mem[33] = 32'h0202_0202;
    mem[2]  = 32'h7F80_FF01;  mem[34] = 32'h0203_0405;
    mem[3]  = 32'h0101_0101;  mem[35] = 32'h0101_0101;
    mem[4]  = 32'hAABB_0201;  mem[36] = 32'hCCDD_0101;

    rst = 1'b1;
    start_in = 1'b0; abort_in = 1'b0; signed_in = 1'b0; sat_in = 1'b0;
    addr_a_in = '0; addr_b_in = '0; length_in = '0; addr_out_in = '0;
    s_start = 1'b0; s_sat = 1'b0; s_length = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_status", status_out, 32'h0);
    check("rst_read_req", {31'd0, read_req}, 32'd0);
    check("rst_write_req", {31'd0, write_req}, 32'd0);
    check("rst_write_data", write_data, 32'h0);
    check("rst_read_addr", read_addr, 32'h0);

    run_job("basic", 1'b0, 1'b0, 32'h00, 32'h80, 32'd4, 1'b1, 32'd10, 32'h2, 2);
    run_job("signed_neg", 1'b1, 1'b0, 32'h04, 32'h84, 32'd4, 1'b1, 32'hFFFF_FFF8, 32'h2, 2);
    run_job("unsigned_ff", 1'b0, 1'b0, 32'h04, 32'h84, 32'd4, 1'b1, 32'h0000_07F8, 32'h2, 2);
    run_job("signed_mix", 1'b1, 1'b0, 32'h08, 32'h88, 32'd4, 1'b1, 32'hFFFF_FF7F, 32'h2, 2);
    run_job("unsigned_mix", 1'b0, 1'b0, 32'h08, 32'h88, 32'd4, 1'b1, 32'h0000_067F, 32'h2, 2);
    run_job("ragged6", 1'b0, 1'b0, 32'h0C, 32'h8C, 32'd6, 1'b1, 32'd7, 32'h2, 4);
    run_job("len0", 1'b0, 1'b0, 32'h00, 32'h80, 32'd0, 1'b1, 32'd0, 32'h2, 0);

    // Abort while idle leaves status untouched.
    abort_in = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_abort_status", status_out, 32'h2);
    // Start edge with abort already high: start wins, abort lands on the next cycle.
    run_job("start_abort", 1'b0, 1'b0, 32'h00, 32'h80, 32'd4, 1'b0, 32'd0, 32'h8, 0);
    abort_in = 1'b0;

    // Abort with a read outstanding against a 3-cycle memory.
    @(negedge clk);
    mem_lat = 3;
    signed_in = 1'b0; sat_in = 1'b0; addr_a_in = 32'h00; addr_b_in = 32'h80;
    length_in = 32'd4; addr_out_in = ResAddr;
    r0 = rd_cnt;
    start_in = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (read_req) begin
        seen = 1'b1;
        break;
      end
    end
    check("abort_req_seen", {31'd0, seen}, 32'd1);
    abort_in = 1'b1;
    wait_idle("abort_pend", 50);
    start_in = 1'b0;
    abort_in = 1'b0;
    check("abort_status", status_out, 32'h8);
    check("abort_reads", 32'(rd_cnt - r0), 32'd1);
    check("abort_write_req", {31'd0, write_req}, 32'd0);
    mem_lat = 1;
    run_job("after_abort", 1'b0, 1'b0, 32'h00, 32'h80, 32'd4, 1'b1, 32'd10, 32'h2, 2);

    // Reset in the middle of a job.
    @(negedge clk);
    length_in = 32'd4;
    start_in = 1'b1;
    repeat (3) @(negedge clk);
    start_in = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_status", status_out, 32'h0);
    check("midrst_read_req", {31'd0, read_req}, 32'd0);
    check("midrst_write_data", write_data, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // 300 words of 255*255 per lane into a 16-bit accumulator.
    run16("sat16", 1'b1, 32'h0000_FFFF);
    run16("wrap16", 1'b0, 32'h0000_A4B0);

    repeat (3) @(negedge clk);
    check("pending_writes", 32'(exp_q.size()), 32'd0);
    check("pending_writes16", 32'(exp16_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
